// File: rtl/aes_job_scheduler.sv
// Round-robin scheduler sharing one iterative AES-128 core between NREQ requesters,
// with a completion timeout on the core and a single id-tagged response channel.
module aes_job_scheduler #(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned ID_W    = 2,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [128*NREQ-1:0]    req_plain,
   input  logic [128*NREQ-1:0]    req_key,
   output logic [NREQ-1:0]        req_ready,
   output logic                   core_start,
   output logic [127:0]           core_plain,
   output logic [127:0]           core_key,
   input  logic                   core_done,
   input  logic [127:0]           core_cipher,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [ID_W-1:0]        rsp_id,
   output logic [127:0]           rsp_cipher,
   output logic                   rsp_err,
   output logic [15:0]            jobs_done
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t            state;
   logic [ID_W-1:0]   rr_ptr;
   logic [ID_W-1:0]   cur_id;
   logic [ID_W-1:0]   grant;
   logic              found;
   logic [ID_W:0]     scan;
   logic [127:0]      sel_plain;
   logic [127:0]      sel_key;
   logic [CNT_W-1:0]  cnt;

   // First pending requester at or after rr_ptr, wrapping modulo NREQ.
   always_comb begin
      found = 1'b0;
      grant = '0;
      scan  = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         scan = {1'b0, rr_ptr} + (ID_W+1)'(i);
         if (scan >= (ID_W+1)'(NREQ)) scan = scan - (ID_W+1)'(NREQ);
         if (!found && req_valid[scan[ID_W-1:0]]) begin
            found = 1'b1;
            grant = scan[ID_W-1:0];
         end
      end
   end

   always_comb begin
      sel_plain = '0;
      sel_key   = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (grant == ID_W'(i)) begin
            sel_plain = req_plain[128*i +: 128];
            sel_key   = req_key[128*i +: 128];
         end
      end
   end

   // Accept strobe is combinational; held low while reset is asserted.
   always_comb begin
      req_ready = '0;
      if (rstn && state == IDLE && found) req_ready[grant] = 1'b1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         cur_id     <= '0;
         cnt        <= '0;
         core_start <= 1'b0;
         core_plain <= '0;
         core_key   <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= '0;
         rsp_cipher <= '0;
         rsp_err    <= 1'b0;
         jobs_done  <= '0;
      end else begin
         core_start <= 1'b0;
         case (state)
            IDLE: begin
               if (found) begin
                  cur_id     <= grant;
                  core_plain <= sel_plain;
                  core_key   <= sel_key;
                  core_start <= 1'b1;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               cnt   <= '0;
               state <= WAIT;
            end
            WAIT: begin
               cnt <= cnt + CNT_W'(1);
               // A done coinciding with the last timeout cycle is still a good result.
               if (core_done) begin
                  rsp_cipher <= core_cipher;
                  rsp_err    <= 1'b0;
                  rsp_id     <= cur_id;
                  rsp_valid  <= 1'b1;
                  state      <= RESP;
               end else if (cnt == CNT_W'(TIMEOUT-1)) begin
                  rsp_cipher <= '0;
                  rsp_err    <= 1'b1;
                  rsp_id     <= cur_id;
                  rsp_valid  <= 1'b1;
                  state      <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  rr_ptr    <= (cur_id == ID_W'(NREQ-1)) ? '0 : cur_id + ID_W'(1);
                  jobs_done <= jobs_done + 16'd1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
